tw_rom_seq_ctrl: RTL and testbench
==================================

TW_ROM_SEQ_CTRL -- requirements
Module: tw_rom_seq_ctrl

Interface
REQ-001 SHALL have parameter STAGE_NUM, default 3, meaning number of stages sequenced (stage_counter 0..STAGE_NUM-1).
REQ-002 SHALL have parameter STAGE_LEN, default 256, meaning active cycles per stage (CEN low).
REQ-003 SHALL have parameter GAP_LEN, default 4, meaning idle cycles between stages (CEN high), minimum 1.
REQ-004 SHALL have parameter HDW, default 64, meaning horizontal word width (half of a 128-bit twiddle entry).
REQ-005 SHALL have one clock and an asynchronous, active-high reset, ports listed first:
REQ-006 SHALL have port CLK, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, begin a sequence; sampled only in IDLE.
REQ-009 SHALL have port load_en, input, 1, sampled with start; 1 = reload stage-0 twiddles before run.
REQ-010 SHALL have port abort, input, 1, synchronous abort of any sequence.
REQ-011 SHALL have port s_valid, input, 1, host word valid.
REQ-012 SHALL have port s_data, input, HDW, host twiddle half-word.
REQ-013 SHALL have port s_ready, output, 1, controller accepts s_data.
REQ-014 SHALL have port stage_counter, output, 3, stage index to twiddle ROM.
REQ-015 SHALL have port CEN, output, 1, active-low ROM enable.
REQ-016 SHALL have port state, output, 4, datapath phase code to ROM.
REQ-017 SHALL have port ROM1_w, output, 2, 0 = none, 1 = write high halves, 2 = write low halves.
REQ-018 SHALL have port horizontal_data_out, output, HDW, word written to ROM.
REQ-019 SHALL have port busy, output, 1, high whenever FSM is not IDLE.
REQ-020 SHALL have port done, output, 1, one-cycle pulse at end of sequence.

Function
REQ-021 SHALL implement FSM states IDLE, HI_FILL, HI_BURST, LO_FILL, LO_BURST, RUN, GAP, DONE.
REQ-022 SHALL, in IDLE with start=1, go to HI_FILL if load_en=1, else to RUN with stage_counter=0, on the next cycle.
REQ-023 SHALL, in HI_FILL and LO_FILL, drive s_ready=1 and store each accepted word (s_valid&s_ready) into a 4-entry buffer at index 0..3 in arrival order.
REQ-024 SHALL drive s_ready=0 in every state other than HI_FILL and LO_FILL.
REQ-025 SHALL leave a FILL state on the cycle after the 4th accepted word, entering the matching BURST state.
REQ-026 SHALL, in a BURST state, drive ROM1_w (1 in HI_BURST, 2 in LO_BURST) for exactly 4 consecutive cycles, with horizontal_data_out = buffer[0..3] in order; ROM1_w SHALL never be non-zero for fewer than 4 contiguous cycles.
REQ-027 SHALL go HI_BURST -> LO_FILL, and LO_BURST -> RUN with stage_counter=0.
REQ-028 SHALL drive ROM1_w=0 outside BURST states, and CEN=1 in all states except RUN.
REQ-029 SHALL, in RUN, drive CEN=0 and state=4 for exactly STAGE_LEN cycles, then go to GAP.
REQ-030 SHALL, in GAP, drive CEN=1 and state=2 for GAP_LEN cycles, then go to RUN with stage_counter+1, or to DONE if stage_counter = STAGE_NUM-1.
REQ-031 SHALL, in DONE, pulse done=1 for one cycle, then return to IDLE with stage_counter=0.
REQ-032 SHALL drive state=0 in all states except RUN and GAP.
REQ-033 SHALL, on abort=1 in any state, enter IDLE next cycle with all outputs at reset values; abort SHALL take priority over start and every other transition.
REQ-034 SHALL ignore start while busy=1.
REQ-035 SHALL not advance a fill when s_valid=0 (unlimited stall).

Reset
REQ-036 SHALL, while rst=1, immediately force IDLE and stage_counter=0, CEN=1, state=0, ROM1_w=0, horizontal_data_out=0, s_ready=0, busy=0, done=0, and clear buffer and counters; a mid-burst reset SHALL drop ROM1_w to 0 without waiting for a clock.

Structure
REQ-037 SHALL keep the FSM encoding, ROM1_w codes (NONE=0, HI=1, LO=2) and state codes (IDLE=0, GAP=2, ACTIVE=4) in a shared package tw_ctrl_pkg.
REQ-038 SHALL place the 4x HDW fill/drain buffer with its write and read indices in one sub-module, tw_word_buf.

Verification
REQ-039 SHALL test that start with load_en=0 and STAGE_NUM=3, STAGE_LEN=8, GAP_LEN=2 gives CEN low 8 cycles each for stage_counter 0, 1, 2 with 2-cycle gaps, then a single done pulse.
REQ-040 SHALL test that start with load_en=1 and words A0..A3 then B0..B3 gives ROM1_w=1 for 4 cycles with A0..A3, then ROM1_w=2 for 4 cycles with B0..B3, then RUN.
REQ-041 SHALL test that deasserting s_valid for 5 cycles after the 2nd word leaves ROM1_w=0 and the buffer unchanged, and that the burst starts 1 cycle after the 4th word.
REQ-042 SHALL test that abort during HI_BURST cycle 2 gives ROM1_w=0, CEN=1 and busy=0 on the next cycle.
REQ-043 SHALL test that asserting rst during RUN forces CEN=1 and stage_counter=0 asynchronously, and that a fresh start afterwards runs normally.
REQ-044 SHALL test that start pulses during RUN are ignored, giving exactly one done pulse.

Source files
------------

// File: rtl/tw_ctrl_pkg.sv
// Shared encodings for the twiddle ROM sequencer.
// FSM states, ROM write codes and datapath phase codes.
package tw_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HI_FILL  = 3'd1,
    S_HI_BURST = 3'd2,
    S_LO_FILL  = 3'd3,
    S_LO_BURST = 3'd4,
    S_RUN      = 3'd5,
    S_GAP      = 3'd6,
    S_DONE     = 3'd7
  } fsm_e;

  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_HI   = 2'd1,
    W_LO   = 2'd2
  } rom_w_e;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_GAP    = 4'd2;
  localparam logic [3:0] ST_ACTIVE = 4'd4;

  localparam int BUF_DEPTH = 4;

endpackage

// File: rtl/tw_word_buf.sv
// Four-entry fill/drain buffer for host twiddle half-words.
// Write and read indices wrap, so each fill/burst pair starts at 0.
module tw_word_buf
  import tw_ctrl_pkg::*;
#(
  parameter int HDW = 64
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [HDW-1:0] wr_data,
  input  logic           rd_en,
  output logic [HDW-1:0] rd_data,
  output logic           wr_last,
  output logic           rd_last
);

  logic [HDW-1:0] mem [BUF_DEPTH];
  logic [1:0]     wr_idx;
  logic [1:0]     rd_idx;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
    end else if (clr) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= wr_data;
        wr_idx      <= wr_idx + 2'd1;
      end
      if (rd_en) rd_idx <= rd_idx + 2'd1;
    end
  end

  assign rd_data = mem[rd_idx];
  assign wr_last = wr_en && (wr_idx == 2'd3);
  assign rd_last = rd_en && (rd_idx == 2'd3);

endmodule

// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle ROM sequencer: optional hi/lo reload bursts, then
// STAGE_NUM run windows separated by idle gaps.
module tw_rom_seq_ctrl
  import tw_ctrl_pkg::*;
#(
  parameter int STAGE_NUM = 3,
  parameter int STAGE_LEN = 256,
  parameter int GAP_LEN   = 4,
  parameter int HDW       = 64
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           start,
  input  logic           load_en,
  input  logic           abort,
  input  logic           s_valid,
  input  logic [HDW-1:0] s_data,
  output logic           s_ready,
  output logic [2:0]     stage_counter,
  output logic           CEN,
  output logic [3:0]     state,
  output logic [1:0]     ROM1_w,
  output logic [HDW-1:0] horizontal_data_out,
  output logic           busy,
  output logic           done
);

  localparam int MAXL = (STAGE_LEN > GAP_LEN) ? STAGE_LEN : GAP_LEN;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] RUN_END = CW'(STAGE_LEN - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_LEN - 1);
  localparam logic [2:0]    STG_END = 3'(STAGE_NUM - 1);

  fsm_e           fsm_q, fsm_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     stg_q, stg_d;
  logic           fill, burst;
  logic           wr_last, rd_last;
  logic [HDW-1:0] rd_data;

  assign fill  = (fsm_q == S_HI_FILL) || (fsm_q == S_LO_FILL);
  assign burst = (fsm_q == S_HI_BURST) || (fsm_q == S_LO_BURST);

  tw_word_buf #(.HDW(HDW)) u_buf (
    .CLK     (CLK),
    .rst     (rst),
    .clr     (abort),
    .wr_en   (fill && s_valid),
    .wr_data (s_data),
    .rd_en   (burst),
    .rd_data (rd_data),
    .wr_last (wr_last),
    .rd_last (rd_last)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      cnt_q <= '0;
      stg_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      stg_q <= stg_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    stg_d = stg_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          fsm_d = load_en ? S_HI_FILL : S_RUN;
          cnt_d = '0;
          stg_d = '0;
        end
      end
      S_HI_FILL:  if (wr_last) fsm_d = S_HI_BURST;
      S_HI_BURST: if (rd_last) fsm_d = S_LO_FILL;
      S_LO_FILL:  if (wr_last) fsm_d = S_LO_BURST;
      S_LO_BURST: begin
        if (rd_last) begin
          fsm_d = S_RUN;
          cnt_d = '0;
          stg_d = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == RUN_END) begin
          fsm_d = S_GAP;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (stg_q == STG_END) begin
            fsm_d = S_DONE;
          end else begin
            fsm_d = S_RUN;
            stg_d = stg_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        fsm_d = S_IDLE;
        stg_d = '0;
      end
      default: fsm_d = S_IDLE;
    endcase
    // abort overrides every transition, including a start in IDLE
    if (abort) begin
      fsm_d = S_IDLE;
      cnt_d = '0;
      stg_d = '0;
    end
  end

  always_comb begin
    ROM1_w = W_NONE;
    state  = ST_IDLE;
    unique case (1'b1)
      fsm_q == S_HI_BURST: ROM1_w = W_HI;
      fsm_q == S_LO_BURST: ROM1_w = W_LO;
      fsm_q == S_RUN:      state  = ST_ACTIVE;
      fsm_q == S_GAP:      state  = ST_GAP;
      default: ;
    endcase
  end

  assign s_ready             = fill;
  assign horizontal_data_out = burst ? rd_data : '0;
  assign CEN                 = (fsm_q != S_RUN);
  assign busy                = (fsm_q != S_IDLE);
  assign done                = (fsm_q == S_DONE);
  assign stage_counter       = stg_q;

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Bench for tw_rom_seq_ctrl: timeline/queue model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_tw_rom_seq_ctrl;

  localparam int SN  = 3;
  localparam int SL  = 8;
  localparam int GL  = 2;
  localparam int HDW = 64;
  localparam int P   = SL + GL;
  localparam int SEQ_END = SN * P;

  logic           CLK = 1'b0;
  logic           rst;
  logic           start, load_en, abort, s_valid;
  logic [HDW-1:0] s_data;
  logic           s_ready;
  logic [2:0]     stage_counter;
  logic           CEN;
  logic [3:0]     state;
  logic [1:0]     ROM1_w;
  logic [HDW-1:0] horizontal_data_out;
  logic           busy, done;

  tw_rom_seq_ctrl #(
    .STAGE_NUM(SN), .STAGE_LEN(SL), .GAP_LEN(GL), .HDW(HDW)
  ) dut (
    .CLK                 (CLK),
    .rst                 (rst),
    .start               (start),
    .load_en             (load_en),
    .abort               (abort),
    .s_valid             (s_valid),
    .s_data              (s_data),
    .s_ready             (s_ready),
    .stage_counter       (stage_counter),
    .CEN                 (CEN),
    .state               (state),
    .ROM1_w              (ROM1_w),
    .horizontal_data_out (horizontal_data_out),
    .busy                (busy),
    .done                (done)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: sequence position m_k walks 0..SEQ_END-1 across run+gap
  // windows; fills collect words in a queue, bursts drain a copy.
  int             m_k;
  int             m_fill;
  int             m_half;
  bit             m_done;
  bit             m_idle0;
  logic [63:0]    m_words[$];
  logic [63:0]    m_burst[$];

  function automatic bit m_busy();
    return (m_fill != 0) || (m_burst.size() != 0) || (m_k >= 0) || m_done;
  endfunction

  task automatic m_clear();
    m_k = -1;
    m_fill = 0;
    m_half = 0;
    m_done = 0;
    m_words.delete();
    m_burst.delete();
  endtask

  always @(posedge CLK or posedge rst) begin
    if (rst || abort) begin
      m_clear();
    end else begin
      m_idle0 = !m_busy();
      if (m_done) m_done = 0;
      if (m_k >= 0) begin
        if (m_k == SEQ_END - 1) begin
          m_k = -1;
          m_done = 1;
        end else begin
          m_k++;
        end
      end
      if (m_burst.size() != 0) begin
        void'(m_burst.pop_front());
        if (m_burst.size() == 0) begin
          if (m_half == 1) m_fill = 2;
          else m_k = 0;
        end
      end else if (m_fill != 0 && s_valid) begin
        m_words.push_back(s_data);
        if (m_words.size() == 4) begin
          m_burst = m_words;
          m_half = m_fill;
          m_fill = 0;
          m_words.delete();
        end
      end
      if (m_idle0 && start) begin
        if (load_en) m_fill = 1;
        else m_k = 0;
      end
    end
  end

  bit chk_on = 0;

  always @(negedge CLK) begin
    if (chk_on) begin
      bit run;
      run = (m_k >= 0) && ((m_k % P) < SL);
      chk("m_s_ready", s_ready, (m_fill != 0));
      chk("m_rom1_w", ROM1_w, (m_burst.size() != 0) ? m_half : 0);
      chk("m_hdo", horizontal_data_out,
          (m_burst.size() != 0) ? m_burst[0] : 64'd0);
      chk("m_cen", CEN, !run);
      chk("m_state", state, (m_k < 0) ? 0 : (run ? 4 : 2));
      if (!m_done)
        chk("m_stage", stage_counter, (m_k >= 0) ? (m_k / P) : 0);
      chk("m_busy", busy, m_busy());
      chk("m_done", done, m_done);
    end
  end

  bit          rec_on = 0;
  int          rec_w[$];
  logic [63:0] rec_d[$];

  always @(negedge CLK) begin
    if (rec_on && ROM1_w != 2'd0) begin
      rec_w.push_back(int'(ROM1_w));
      rec_d.push_back(horizontal_data_out);
    end
  end

  int lowc[3];
  int gapc, donec, done_at;

  task automatic kick(input bit load);
    start = 1;
    load_en = load;
    @(negedge CLK);
    start = 0;
    load_en = 0;
  endtask

  task automatic observe(input int maxc, input bit poke);
    bit got;
    got = 0;
    lowc = '{0, 0, 0};
    gapc = 0;
    donec = 0;
    done_at = 0;
    for (int c = 1; c <= maxc; c++) begin
      if (!CEN && stage_counter < 3) lowc[stage_counter]++;
      if (busy && state == 4'd2) gapc++;
      if (done) begin
        donec++;
        done_at = c;
        got = 1;
      end
      start = poke && !CEN && (c % 3 == 0);
      @(negedge CLK);
      if (got && !busy) break;
    end
    start = 0;
    chk("observe_done_seen", got, 1'b1);
  endtask

  task automatic check_seq(input string tag, input int at);
    chk({tag, "_low0"}, lowc[0], 8);
    chk({tag, "_low1"}, lowc[1], 8);
    chk({tag, "_low2"}, lowc[2], 8);
    chk({tag, "_gaps"}, gapc, 6);
    chk({tag, "_donec"}, donec, 1);
    chk({tag, "_done_at"}, done_at, at);
  endtask

  task automatic send4(input logic [63:0] w0, input logic [63:0] w1,
                       input logic [63:0] w2, input logic [63:0] w3,
                       input int stall_at, input int stall_len);
    logic [63:0] w[4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      int n;
      if (i == stall_at) begin
        s_valid = 0;
        repeat (stall_len) @(negedge CLK);
      end
      n = 0;
      while (!s_ready && n < 20) begin
        @(negedge CLK);
        n++;
      end
      chk("s_ready_wait", s_ready, 1'b1);
      s_valid = 1;
      s_data = w[i];
      @(negedge CLK);
    end
    s_valid = 0;
    s_data = '0;
  endtask

  logic [63:0] A[4] = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
  logic [63:0] B[4] = '{64'hB0, 64'hB1, 64'hB2, 64'hB3};
  logic [63:0] C[4] = '{64'hC0DE_0000, 64'hC0DE_0001,
                        64'hC0DE_0002, 64'hC0DE_0003};
  logic [63:0] D[4] = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
  logic [63:0] E[4] = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; load_en = 0; abort = 0;
    s_valid = 0; s_data = '0;
    m_clear();
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cen", CEN, 1'b1);
    chk("rst_rom1_w", ROM1_w, 2'd0);
    chk("rst_state", state, 4'd0);
    chk("rst_stage", stage_counter, 3'd0);
    chk("rst_sready", s_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 0;
    chk_on = 1;
    @(negedge CLK);

    // plain sequence without reload
    kick(0);
    observe(100, 0);
    check_seq("plain", 31);

    // hi/lo reload then run
    rec_w.delete(); rec_d.delete(); rec_on = 1;
    kick(1);
    send4(A[0], A[1], A[2], A[3], -1, 0);
    chk("hi_first_w", ROM1_w, 2'd1);
    chk("hi_first_d", horizontal_data_out, A[0]);
    send4(B[0], B[1], B[2], B[3], -1, 0);
    chk("lo_first_w", ROM1_w, 2'd2);
    observe(100, 0);
    check_seq("load", 35);
    rec_on = 0;
    chk("rec_len", rec_w.size(), 8);
    if (rec_w.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("rec_w", rec_w[i], (i < 4) ? 1 : 2);
        chk("rec_d", rec_d[i], (i < 4) ? A[i] : B[i - 4]);
      end
    end

    // stalled fill
    rec_w.delete(); rec_d.delete(); rec_on = 1;
    kick(1);
    send4(C[0], C[1], C[2], C[3], 2, 5);
    chk("stall_burst_next", ROM1_w, 2'd1);
    send4(D[0], D[1], D[2], D[3], -1, 0);
    observe(100, 0);
    rec_on = 0;
    chk("stall_rec_len", rec_w.size(), 8);
    if (rec_w.size() == 8) begin
      for (int i = 0; i < 4; i++) chk("stall_rec_d", rec_d[i], C[i]);
    end

    // abort in second hi-burst cycle
    kick(1);
    send4(E[0], E[1], E[2], E[3], -1, 0);
    chk("ab_b1_d", horizontal_data_out, E[0]);
    @(negedge CLK);
    chk("ab_b2_d", horizontal_data_out, E[1]);
    abort = 1;
    @(negedge CLK);
    abort = 0;
    chk("ab_rom1_w", ROM1_w, 2'd0);
    chk("ab_cen", CEN, 1'b1);
    chk("ab_busy", busy, 1'b0);

    // async reset during stage 1 run
    kick(0);
    repeat (12) @(negedge CLK);
    chk("pre_rst_stage", stage_counter, 3'd1);
    chk("pre_rst_cen", CEN, 1'b0);
    #3 rst = 1;
    #1;
    chk("arst_cen", CEN, 1'b1);
    chk("arst_stage", stage_counter, 3'd0);
    chk("arst_busy", busy, 1'b0);
    @(negedge CLK);
    rst = 0;
    @(negedge CLK);
    kick(0);
    observe(100, 0);
    check_seq("post_rst", 31);

    // start pulses while running are ignored
    kick(0);
    observe(100, 1);
    check_seq("poke", 31);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
